// File: rtl/foo_reduce.sv
// -----------------------------------------------------------------------------
// foo_reduce
//
// Pipelined bitwise reduction combiner. Each accepted beat carries CHANNELS
// operands of WIDTH bits; the channels selected by in_mask are folded together
// with AND, OR or XOR. The result goes through one register stage (s1) and is
// then pushed into a DEPTH-entry FIFO drained by a valid/ready consumer.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   producer has a beat
//   in_ready   block can accept a beat this cycle (registered)
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_mask    1 = channel i participates in the reduction
//   mode       00 AND, 01 OR, 10 XOR, 11 reserved (result 0, sets err)
//   out_valid  FIFO head is valid (registered)
//   out_ready  consumer takes the head this cycle
//   out_data   FIFO head result
//   count      FIFO occupancy
//   beats      accepted-beat counter, wraps modulo 2^BEATW
//   err        sticky flag: a reserved-mode beat was accepted
// -----------------------------------------------------------------------------
module foo_reduce #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  parameter int BEATW    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS-1:0]          in_mask,
  input  logic [1:0]                   mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [BEATW-1:0]             beats,
  output logic                         err
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam logic [CNTW:0] DEPTH_W = DEPTH[CNTW:0];

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  // Fold the masked channels with the selected operator. Unmasked channels
  // contribute nothing, so the accumulator starts at the operator identity.
  function automatic logic [WIDTH-1:0] reduce_fn(
    input logic [CHANNELS*WIDTH-1:0] data,
    input logic [CHANNELS-1:0]       mask,
    input logic [1:0]                op
  );
    logic [WIDTH-1:0] acc;
    case (op)
      MODE_AND: begin
        acc = {WIDTH{1'b1}};
        for (int i = 0; i < CHANNELS; i++) begin
          if (mask[i]) begin
            acc = acc & data[i*WIDTH +: WIDTH];
          end else begin
            acc = acc;
          end
        end
      end
      MODE_OR: begin
        acc = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
          if (mask[i]) begin
            acc = acc | data[i*WIDTH +: WIDTH];
          end else begin
            acc = acc;
          end
        end
      end
      MODE_XOR: begin
        acc = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
          if (mask[i]) begin
            acc = acc ^ data[i*WIDTH +: WIDTH];
          end else begin
            acc = acc;
          end
        end
      end
      MODE_RSVD: acc = {WIDTH{1'b0}};
      default:   acc = {WIDTH{1'b0}};
    endcase
    return acc;
  endfunction

  // State
  logic                 s1_valid_r;
  logic [WIDTH-1:0]     s1_data_r;
  logic [WIDTH-1:0]     mem_r [DEPTH];
  logic [PTRW-1:0]      wr_ptr_r;
  logic [PTRW-1:0]      rd_ptr_r;
  logic [CNTW-1:0]      count_r;
  logic [BEATW-1:0]     beats_r;
  logic                 err_r;
  logic                 in_ready_r;
  logic                 out_valid_r;

  // Next-state helpers
  logic                 accept_s;
  logic                 push_s;
  logic                 pop_s;
  logic [CNTW-1:0]      count_nxt_s;
  logic                 ready_nxt_s;
  logic                 out_valid_nxt_s;

  assign accept_s = in_valid & in_ready_r;
  // s1 always has a FIFO slot reserved for it by the credit rule, so the push
  // never needs to look at FIFO fullness.
  assign push_s   = s1_valid_r;
  assign pop_s    = out_valid_r & out_ready;

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNTW'(1);
      2'b01:   count_nxt_s = count_r - CNTW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // in_ready and out_valid are precomputed from the next register state so
  // that both leave the block straight from flops. s1_valid next equals
  // accept_s, which is why the credit term uses accept_s here.
  assign ready_nxt_s     = ({1'b0, count_nxt_s} + {{CNTW{1'b0}}, accept_s}) < DEPTH_W;
  assign out_valid_nxt_s = (count_nxt_s != {CNTW{1'b0}});

  // Stage 1: capture the reduced result of an accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {WIDTH{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= reduce_fn(in_data, in_mask, mode);
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s1_data_r;
    end
  end

  // FIFO pointers, occupancy and registered handshake flags. DEPTH is a power
  // of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {PTRW{1'b0}};
      rd_ptr_r    <= {PTRW{1'b0}};
      count_r     <= {CNTW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTRW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTRW'(1);
      end
      count_r     <= count_nxt_s;
      in_ready_r  <= ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Accepted-beat counter and sticky reserved-mode flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      beats_r <= {BEATW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        beats_r <= beats_r + BEATW'(1);
        if (mode == MODE_RSVD) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign beats     = beats_r;
  assign err       = err_r;

endmodule

// File: tb/tb_foo_reduce.sv
// -----------------------------------------------------------------------------
// tb_foo_reduce
//
// Directed checks with hand-computed values followed by a random soak. Inputs
// are driven at the falling edge, outputs sampled there too. A queue of
// expected results, filled from an independent reduction model on every
// accept, checks order and content of every popped result.
// -----------------------------------------------------------------------------
module tb_foo_reduce;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 4;
  localparam int BEATW    = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        in_valid;
  logic                        in_ready;
  logic [CHANNELS*WIDTH-1:0]   in_data;
  logic [CHANNELS-1:0]         in_mask;
  logic [1:0]                  mode;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [2:0]                  count;
  logic [BEATW-1:0]            beats;
  logic                        err;

  int               pass_cnt  = 0;
  int               total_cnt = 0;
  int               pops_n    = 0;
  logic [7:0]       exp_q[$];
  logic [BEATW-1:0] beats_m;
  logic             err_m;
  logic             acc_l;

  always #5 clk = ~clk;

  foo_reduce #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .BEATW(BEATW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mask(in_mask), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .beats(beats), .err(err)
  );

  function automatic logic [7:0] ref_reduce(input logic [31:0] d, input logic [3:0] m,
                                            input logic [1:0] md);
    logic [7:0] r;
    logic [7:0] ch;
    if (md == 2'b11) return 8'h00;
    r = (md == 2'b00) ? 8'hFF : 8'h00;
    for (int i = 0; i < 4; i++) begin
      ch = d[i*8 +: 8];
      if (m[i]) begin
        if (md == 2'b00)      r = r & ch;
        else if (md == 2'b01) r = r | ch;
        else                  r = r ^ ch;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One clock: drive inputs at the falling edge, predict accept/pop from the
  // registered handshake outputs, then advance to the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [3:0] m,
                       input logic [1:0] md, input logic ordy, output logic acc_o);
    logic pop;
    in_valid  = v;
    in_data   = d;
    in_mask   = m;
    mode      = md;
    out_ready = ordy;
    acc_o = v && in_ready;
    pop   = out_valid && ordy;
    if (pop) begin
      pops_n++;
      if (exp_q.size() == 0) chk("out_valid_when_model_empty", {31'd0, out_valid}, 32'd0);
      else                   chk("out_order", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
    if (acc_o) begin
      exp_q.push_back(ref_reduce(d, m, md));
      beats_m = beats_m + 4'd1;
      if (md == 2'b11) err_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    exp_q.delete();
    beats_m = 4'd0;
    err_m   = 1'b0;
  endtask

  // Single beat from an empty FIFO: accept, wait for the FIFO write, check the
  // head against the hand value, then pop it.
  task automatic single(input string tag, input logic [31:0] d, input logic [3:0] m,
                        input logic [1:0] md, input logic [7:0] expv);
    logic a;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    cycle(1'b1, d, m, md, 1'b0, a);
    cycle(1'b0, d, m, md, 1'b0, a);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out_data"}, {24'd0, out_data}, {24'd0, expv});
    cycle(1'b0, d, m, md, 1'b1, a);
  endtask

  task automatic drain(input string tag);
    int   n = 0;
    logic a;
    while (exp_q.size() != 0 && n < 40) begin
      cycle(1'b0, 32'd0, 4'd0, 2'd0, 1'b1, a);
      n++;
    end
    chk({tag, "_all_results_seen"}, exp_q.size(), 32'd0);
    chk({tag, "_out_valid_low"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int k;
    int n;
    int pops_start;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'd0; in_mask = 4'd0; mode = 2'd0;
    beats_m = 4'd0; err_m = 1'b0;

    // Reset state
    do_reset();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_beats", {28'd0, beats}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // AND over all channels: F0 & 3C & FF & F5 = 30, two-cycle latency
    cycle(1'b1, 32'hF5FF3CF0, 4'b1111, 2'b00, 1'b0, acc_l);
    chk("and_beats", {28'd0, beats}, 32'd1);
    chk("and_count_after_t", {29'd0, count}, 32'd0);
    chk("and_valid_after_t", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 32'd0, 4'd0, 2'd0, 1'b0, acc_l);
    chk("and_valid_after_t1", {31'd0, out_valid}, 32'd1);
    chk("and_data", {24'd0, out_data}, 32'h30);
    chk("and_count_after_t1", {29'd0, count}, 32'd1);
    cycle(1'b0, 32'd0, 4'd0, 2'd0, 1'b1, acc_l);

    // XOR of ch0 and ch2: 0F ^ F0 = FF
    single("xor_partial", 32'h55F0AA0F, 4'b0101, 2'b10, 8'hFF);
    // Empty mask yields the operator identity
    single("empty_and", 32'h12345678, 4'b0000, 2'b00, 8'hFF);
    single("empty_or",  32'h12345678, 4'b0000, 2'b01, 8'h00);
    single("empty_xor", 32'h12345678, 4'b0000, 2'b10, 8'h00);
    chk("beats_after_directed", {28'd0, beats}, 32'd5);

    // Backpressure: consumer stalled, producer streams 01..06 via OR on ch0
    pops_start = pops_n;
    k = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, k, 4'b0001, 2'b01, 1'b0, acc_l);
      if (acc_l) k++;
    end
    chk("bp_accepted", k - 1, 32'd4);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_count_full", {29'd0, count}, 32'd4);
    n = 0;
    while (k <= 6 && n < 30) begin
      cycle(1'b1, k, 4'b0001, 2'b01, 1'b1, acc_l);
      if (acc_l) k++;
      n++;
    end
    drain("bp");
    chk("bp_pop_total", pops_n - pops_start, 32'd6);

    // Reserved mode sets a sticky err and yields zero
    single("rsvd", 32'hFFFFFFFF, 4'b1111, 2'b11, 8'h00);
    chk("rsvd_err_set", {31'd0, err}, 32'd1);
    single("and_after_rsvd", 32'hFFFFFFFF, 4'b1111, 2'b00, 8'hFF);
    chk("rsvd_err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("rsvd_err_cleared", {31'd0, err}, 32'd0);

    // Reset mid-stream with three stored results
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h10 + i, 4'b0001, 2'b01, 1'b0, acc_l);
    cycle(1'b0, 32'd0, 4'd0, 2'd0, 1'b0, acc_l);
    chk("mid_count_3", {29'd0, count}, 32'd3);
    do_reset();
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_beats", {28'd0, beats}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    single("post_reset_first", 32'h00000077, 4'b0001, 2'b01, 8'h77);
    drain("post_reset");

    // Random soak against the scoreboard; BEATW=4 makes beats wrap often
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc_l);
      chk("soak_count_bound", {31'd0, (count <= 3'd4)}, 32'd1);
      chk("soak_beats", {28'd0, beats}, {28'd0, beats_m});
      chk("soak_err", {31'd0, err}, {31'd0, err_m});
    end
    drain("soak");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
